uart_cmd_responder: RTL and testbench
=====================================

// Module: uart_cmd_responder
// PURPOSE
//  Host-facing command responder on the parallel side of the UART core. Takes each received
//  16-bit word (rx_ready/rx_data/rx_ready_clr) as a command, executes it against a small
//  register file and returns one 16-bit response word through the transmitter
//  (tx_en/tx_data/tx_busy). The FPGA is the responder; the PC-side initiator is the host.
// PARAMETERS
//  NUM_REGS      16    number of 8-bit registers, 1..64; addr >= NUM_REGS is invalid
//  BUSY_TIMEOUT  1024  clk cycles allowed for tx_busy to rise after tx_en
// PORTS
//  clk_50m      in   1           system clock, 50 MHz
//  rst_n        in   1           synchronous, active-low reset
//  rx_ready     in   1           UART receiver holds a word
//  rx_data      in   16          received command word
//  rx_ready_clr out  1           1-cycle pulse: command consumed
//  tx_data      out  16          response word, stable from tx_en until tx_busy falls
//  tx_en        out  1           1-cycle transmit request
//  tx_busy      in   1           transmitter busy
//  reg_out      out  NUM_REGS*8  flat register contents, reg[i] at [8i+7:8i]
//  busy         out  1           high whenever state != IDLE
//  err          out  1           1-cycle pulse on bad address or tx timeout
// BEHAVIOUR
//  Command: [15:14] op, [13:8] addr, [7:0] data. Ops: 00 NOP, 01 WRITE, 10 READ, 11 ECHO.
//  Response: {status[1:0], addr, data}. Status: 01 write ok (data = written value),
//   10 read ok (data = reg[addr]), 11 echo (data = cmd data), 00 error (data = 8'h00).
//   NOP sends no response. Bad addr on WRITE/READ: no reg change, status 00, err pulse.
//  Reset: state IDLE; all regs 8'h00; tx_data 0; tx_en, rx_ready_clr, err, busy = 0.
//  FSM:
//   IDLE: rx_ready=1 -> latch rx_data, pulse rx_ready_clr -> EXEC.
//   EXEC: one cycle. Apply write; form response. NOP -> IDLE. Otherwise -> TX_REQ.
//   TX_REQ: wait for tx_busy=0, then pulse tx_en -> TX_WAIT_BUSY.
//   TX_WAIT_BUSY: tx_busy=1 -> TX_WAIT_DONE. Else after BUSY_TIMEOUT cycles -> err pulse, IDLE.
//   TX_WAIT_DONE: tx_busy=0 -> IDLE.
//  Latency: rx_ready seen -> tx_en is 3 cycles when tx_busy is already low.
//  rx_ready while not IDLE: ignored. The UART holds the word; it is taken on return to IDLE.
//   No command is dropped by the responder.
//  A write is visible on reg_out in the cycle after EXEC. A READ that follows a WRITE to the
//   same address returns the new value.
//  Timeout counter: width clog2(BUSY_TIMEOUT+1); cleared on entry to TX_WAIT_BUSY.
//  Reset mid-operation: FSM is abandoned and tx_en drops at once. The in-flight response is lost.
//   Register contents are cleared.
// CONFIGURATION
//  UART_RESP_STATS_EN defined:
//   - adds output cmd_count[15:0].
//   - cmd_count increments on every rx_ready_clr pulse, including NOP and bad-address commands.
//   - cmd_count wraps 16'hFFFF -> 0 and resets to 0.
//   - command op 11 with addr 6'h3F returns {2'b11, 6'h3F, cmd_count[7:0]} instead of an echo.
//  UART_RESP_STATS_EN undefined: no cmd_count port or counter; op 11 is always an echo.
// STRUCTURE
//  Package uart_resp_pkg holds:
//   - op codes (OP_NOP/OP_WR/OP_RD/OP_ECHO) and status codes (ST_ERR/ST_WR/ST_RD/ST_ECHO);
//   - command field bit positions;
//   - FSM state encoding (IDLE, EXEC, TX_REQ, TX_WAIT_BUSY, TX_WAIT_DONE).
//  Sub-module uart_resp_regfile holds:
//   - NUM_REGS x 8 storage with synchronous write and combinational read;
//   - the flat reg_out output;
//   - sync reset to zero.
//  The FSM, response formation, timeout counter and stats live in the top.
// TESTING
//  1. WRITE 16'h4_3A5 (addr 3, data A5) -> rx_ready_clr pulse; tx_data 16'h43A5; reg_out[31:24]=A5.
//  2. READ 16'h8300 after test 1 -> tx_data 16'h83A5; registers unchanged; err stays 0.
//  3. READ addr 20 with NUM_REGS=16 (16'h9400) -> tx_data 16'h1400; err pulse; no reg change.
//  4. ECHO 16'hC07E, then NOP 16'h0000 -> response 16'hC07E; no tx_en for the NOP.
//  5. Second command held on rx_ready during TX_WAIT_DONE -> consumed only after tx_busy falls.
//     Two responses are sent, in order.
//  6. tx_busy tied 0 -> err pulse exactly BUSY_TIMEOUT cycles after tx_en; FSM back in IDLE.
//     rst_n low mid-TX_WAIT_DONE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/uart_resp_pkg.sv
// uart_resp_pkg: shared definitions for the UART command responder.
//   - command op codes and response status codes
//   - command word field positions
//   - responder FSM state encoding
//   - helpers for address checking and response packing
package uart_resp_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_ECHO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_ERR  = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10,
    ST_ECHO = 2'b11
  } status_e;

  // Command word layout: {op[1:0], addr[5:0], data[7:0]}
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 14;
  localparam int ADDR_MSB = 13;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // ECHO to this address reports the command counter when statistics are built in
  localparam logic [5:0] STATS_ADDR = 6'h3F;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    EXEC         = 3'd1,
    TX_REQ       = 3'd2,
    TX_WAIT_BUSY = 3'd3,
    TX_WAIT_DONE = 3'd4
  } state_e;

  function automatic logic addr_in_range(input logic [5:0] addr, input int num_regs);
    return ({1'b0, addr} < 7'(num_regs));
  endfunction

  function automatic logic [15:0] make_resp(input status_e st, input logic [5:0] addr,
                                            input logic [7:0] data);
    return {st, addr, data};
  endfunction

endpackage

// File: rtl/uart_resp_regfile.sv
// uart_resp_regfile: NUM_REGS x 8-bit register file for the command responder.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset, clears every register
//   wr_en    in   write strobe (address already range-checked by the caller)
//   wr_addr  in   6-bit write address
//   wr_data  in   8-bit write data
//   rd_addr  in   6-bit read address
//   rd_data  out  combinational read data (8'h00 for out-of-range addresses)
//   reg_out  out  flat register contents, reg[i] at [8i+7:8i]
import uart_resp_pkg::*;

module uart_resp_regfile #(
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [5:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [5:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic [NUM_REGS*8-1:0] reg_out
);

  logic [7:0] mem_r [NUM_REGS];

  // Register storage: synchronous clear and write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_r[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (wr_addr == 6'(i))) mem_r[i] <= wr_data;
      end
    end
  end

  // Read mux written as a compare loop so any 6-bit address is safe
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 6'(i)) rd_data = mem_r[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[8*g +: 8] = mem_r[g];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: executes 16-bit host commands received by the UART against a
// small register file and returns one 16-bit response word per command (none for NOP).
// Optional build macro: UART_RESP_STATS_EN adds the cmd_count output and the
// ECHO-to-0x3F counter query.
// Ports:
//   clk_50m       in   50 MHz system clock
//   rst_n         in   synchronous active-low reset
//   rx_ready      in   receiver holds a command word
//   rx_data       in   command {op, addr, data}
//   rx_ready_clr  out  1-cycle pulse, command consumed
//   tx_data       out  response {status, addr, data}, held until the next command executes
//   tx_en         out  1-cycle transmit request
//   tx_busy       in   transmitter busy
//   reg_out       out  flat register contents
//   busy          out  responder not idle
//   err           out  1-cycle pulse on bad address or transmitter timeout
//   cmd_count     out  (UART_RESP_STATS_EN only) consumed-command counter
import uart_resp_pkg::*;

module uart_cmd_responder #(
  parameter int NUM_REGS     = 16,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic                  rx_ready,
  input  logic [15:0]           rx_data,
  output logic                  rx_ready_clr,
  output logic [15:0]           tx_data,
  output logic                  tx_en,
  input  logic                  tx_busy,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  busy,
`ifdef UART_RESP_STATS_EN
  output logic [15:0]           cmd_count,
`endif
  output logic                  err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_e           state_r, next_state_s;
  logic [15:0]      cmd_r;
  logic [CNT_W-1:0] tmo_cnt_r;
  op_e              op_s;
  logic [5:0]       addr_s;
  logic [7:0]       data_s;
  logic             addr_ok_s;
  logic [7:0]       rd_data_s;
  logic [15:0]      resp_s;
  logic             tmo_hit_s;
  logic             rx_ready_clr_s, tx_en_s, err_s, busy_s, wr_en_s, load_resp_s;
`ifdef UART_RESP_STATS_EN
  logic [15:0]      cmd_count_r;
`endif

  assign op_s      = op_e'(cmd_r[OP_MSB:OP_LSB]);
  assign addr_s    = cmd_r[ADDR_MSB:ADDR_LSB];
  assign data_s    = cmd_r[DATA_MSB:DATA_LSB];
  assign addr_ok_s = addr_in_range(addr_s, NUM_REGS);
  // Counter starts at 0 in the tx_en cycle, so the last waiting cycle is BUSY_TIMEOUT-1
  assign tmo_hit_s = (tmo_cnt_r == CNT_W'(BUSY_TIMEOUT - 1));

  uart_resp_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clk_50m),
    .rst_n   (rst_n),
    .wr_en   (wr_en_s),
    .wr_addr (addr_s),
    .wr_data (data_s),
    .rd_addr (addr_s),
    .rd_data (rd_data_s),
    .reg_out (reg_out)
  );

  // FSM state register
  always_ff @(posedge clk_50m) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (rx_ready) next_state_s = EXEC;
        else          next_state_s = IDLE;
      end
      EXEC: begin
        if (op_s == OP_NOP) next_state_s = IDLE;
        else                next_state_s = TX_REQ;
      end
      TX_REQ: begin
        if (!tx_busy) next_state_s = TX_WAIT_BUSY;
        else          next_state_s = TX_REQ;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy)        next_state_s = TX_WAIT_DONE;
        else if (tmo_hit_s) next_state_s = IDLE;
        else                next_state_s = TX_WAIT_BUSY;
      end
      TX_WAIT_DONE: begin
        if (!tx_busy) next_state_s = IDLE;
        else          next_state_s = TX_WAIT_DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output strobes, registered below so every port is driven from a flop
  always_comb begin
    rx_ready_clr_s = 1'b0;
    tx_en_s        = 1'b0;
    err_s          = 1'b0;
    wr_en_s        = 1'b0;
    load_resp_s    = 1'b0;
    busy_s         = (next_state_s != IDLE);
    case (state_r)
      IDLE: rx_ready_clr_s = rx_ready;
      EXEC: begin
        load_resp_s = (op_s != OP_NOP);
        wr_en_s     = (op_s == OP_WR) && addr_ok_s;
        err_s       = ((op_s == OP_WR) || (op_s == OP_RD)) && !addr_ok_s;
      end
      TX_REQ:       tx_en_s = !tx_busy;
      TX_WAIT_BUSY: err_s   = !tx_busy && tmo_hit_s;
      TX_WAIT_DONE: err_s   = 1'b0;
      default:      err_s   = 1'b0;
    endcase
  end

  // Response word for the latched command
  always_comb begin
    resp_s = 16'h0000;
    case (op_s)
      OP_WR: begin
        if (addr_ok_s) resp_s = make_resp(ST_WR, addr_s, data_s);
        else           resp_s = make_resp(ST_ERR, addr_s, 8'h00);
      end
      OP_RD: begin
        if (addr_ok_s) resp_s = make_resp(ST_RD, addr_s, rd_data_s);
        else           resp_s = make_resp(ST_ERR, addr_s, 8'h00);
      end
      OP_ECHO: begin
`ifdef UART_RESP_STATS_EN
        if (addr_s == STATS_ADDR) resp_s = make_resp(ST_ECHO, addr_s, cmd_count_r[7:0]);
        else                      resp_s = make_resp(ST_ECHO, addr_s, data_s);
`else
        resp_s = make_resp(ST_ECHO, addr_s, data_s);
`endif
      end
      default: resp_s = 16'h0000;
    endcase
  end

  // Command latch, response hold, timeout counter and registered outputs
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      cmd_r        <= 16'h0000;
      tx_data      <= 16'h0000;
      tx_en        <= 1'b0;
      rx_ready_clr <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      tmo_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      rx_ready_clr <= rx_ready_clr_s;
      tx_en        <= tx_en_s;
      err          <= err_s;
      busy         <= busy_s;
      if (rx_ready_clr_s) cmd_r <= rx_data;
      // Loaded in EXEC, so tx_data is already stable when tx_en rises
      if (load_resp_s) tx_data <= resp_s;
      if (tx_en_s)                        tmo_cnt_r <= {CNT_W{1'b0}};
      else if (state_r == TX_WAIT_BUSY)   tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      else                                tmo_cnt_r <= tmo_cnt_r;
    end
  end

`ifdef UART_RESP_STATS_EN
  // Counter advances as the command is taken, so a counter query includes itself
  always_ff @(posedge clk_50m) begin
    if (!rst_n)              cmd_count_r <= 16'h0000;
    else if (rx_ready_clr_s) cmd_count_r <= cmd_count_r + 16'h0001;
    else                     cmd_count_r <= cmd_count_r;
  end

  assign cmd_count = cmd_count_r;
`endif

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Testbench for uart_cmd_responder: directed commands, scoreboard of expected responses
// popped by a monitor on every tx_en, plus a simple transmitter model.
module tb_uart_cmd_responder;

  localparam int NUM_REGS     = 16;
  localparam int BUSY_TIMEOUT = 32;
  localparam int BUSY_LEN     = 6;

  logic                  clk_50m = 1'b0;
  logic                  rst_n;
  logic                  rx_ready;
  logic [15:0]           rx_data;
  logic                  rx_ready_clr;
  logic [15:0]           tx_data;
  logic                  tx_en;
  logic                  tx_busy;
  logic [NUM_REGS*8-1:0] reg_out;
  logic                  busy;
  logic                  err;
`ifdef UART_RESP_STATS_EN
  logic [15:0]           cmd_count;
`endif

  always #10 clk_50m = ~clk_50m;

  uart_cmd_responder #(.NUM_REGS(NUM_REGS), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_busy      (tx_busy),
    .reg_out      (reg_out),
    .busy         (busy),
`ifdef UART_RESP_STATS_EN
    .cmd_count    (cmd_count),
`endif
    .err          (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  logic [127:0] exp_regs;
  int tx_count = 0, tx_done_cnt = 0, err_seen = 0;
  int tx_en_cyc = 0, err_cyc = 0, start_cyc = 0, done_at_clr = 0;
  logic err_busy;
  bit tx_dead = 1'b0;
  bit chk_stable = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  initial forever begin
    @(posedge clk_50m);
    cyc++;
  end

  // Scoreboard monitor: every transmit request must carry the oldest expected response
  initial forever begin
    @(negedge clk_50m);
    if (rst_n === 1'b1 && tx_en === 1'b1) begin
      tx_count++;
      tx_en_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %h, expected no response", tx_data);
      end else begin
        check("tx_data", {112'h0, tx_data}, {112'h0, exp_q.pop_front()});
      end
    end
  end

  // Error pulse monitor
  initial forever begin
    @(negedge clk_50m);
    if (rst_n === 1'b1 && err === 1'b1) begin
      err_seen++;
      err_cyc  = cyc;
      err_busy = busy;
    end
  end

  // Transmitter model: busy for BUSY_LEN cycles after each request, tx_data must hold
  initial begin
    logic [15:0] cap;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk_50m);
      if (tx_en === 1'b1 && !tx_dead) begin
        cap = tx_data;
        @(posedge clk_50m);
        #1 tx_busy = 1'b1;
        repeat (BUSY_LEN) begin
          @(negedge clk_50m);
          if (chk_stable) check("tx_data_stable", {112'h0, tx_data}, {112'h0, cap});
        end
        @(posedge clk_50m);
        #1 tx_busy = 1'b0;
        tx_done_cnt++;
      end
    end
  end

  task automatic send_cmd(input logic [15:0] cmd, input bit has_resp, input logic [15:0] resp);
    int n;
    @(posedge clk_50m);
    #1;
    if (has_resp) exp_q.push_back(resp);
    rx_data   = cmd;
    rx_ready  = 1'b1;
    start_cyc = cyc;
    n = 0;
    do begin
      @(negedge clk_50m);
      n++;
    end while (rx_ready_clr !== 1'b1 && n < 400);
    if (n >= 400) fail_now("rx_ready_clr_wait");
    done_at_clr = tx_done_cnt;
    @(posedge clk_50m);
    #1 rx_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk_50m);
      n++;
    end while (!(busy === 1'b0 && tx_busy === 1'b0) && n < 400);
    if (n >= 400) fail_now("idle_wait");
    @(posedge clk_50m);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e0, d0;
    rst_n    = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 16'h0000;
    exp_regs = 128'h0;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    check("rst_tx_en", {127'h0, tx_en}, 128'h0);
    check("rst_rx_ready_clr", {127'h0, rx_ready_clr}, 128'h0);
    check("rst_err", {127'h0, err}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_tx_data", {112'h0, tx_data}, 128'h0);
    check("rst_regs", reg_out, 128'h0);
    @(posedge clk_50m);
    #1 rst_n = 1'b1;

    // WRITE addr 3 = A5, with latency measurement
    send_cmd(16'h43A5, 1'b1, 16'h43A5);
    wait_idle();
    check("latency", 128'(tx_en_cyc - start_cyc), 128'd3);
    exp_regs[31:24] = 8'hA5;
    check("wr_regs", reg_out, exp_regs);

    // READ addr 3
    send_cmd(16'h8300, 1'b1, 16'h83A5);
    wait_idle();
    check("rd_regs", reg_out, exp_regs);
    check("rd_no_err", 128'(err_seen), 128'd0);

    // READ addr 20 (invalid)
    send_cmd(16'h9400, 1'b1, 16'h1400);
    wait_idle();
    check("bad_rd_err", 128'(err_seen), 128'd1);
    check("bad_rd_regs", reg_out, exp_regs);

    // WRITE addr 26 (invalid), WRITE addr 15 (last valid), READ addr 16 (first invalid)
    send_cmd(16'h5A11, 1'b1, 16'h1A00);
    wait_idle();
    check("bad_wr_err", 128'(err_seen), 128'd2);
    check("bad_wr_regs", reg_out, exp_regs);
    send_cmd(16'h4F3C, 1'b1, 16'h4F3C);
    wait_idle();
    exp_regs[127:120] = 8'h3C;
    check("wr_top_regs", reg_out, exp_regs);
    send_cmd(16'h9000, 1'b1, 16'h1000);
    wait_idle();
    check("bad_rd16_err", 128'(err_seen), 128'd3);

    // ECHO then NOP: exactly one transmission
    n = tx_count;
    send_cmd(16'hC07E, 1'b1, 16'hC07E);
    send_cmd(16'h0000, 1'b0, 16'h0000);
    wait_idle();
    repeat (4) @(negedge clk_50m);
    check("nop_no_tx", 128'(tx_count - n), 128'd1);

    // Back-to-back WRITE then READ of the same address
    send_cmd(16'h4211, 1'b1, 16'h4211);
    send_cmd(16'h8200, 1'b1, 16'h8211);
    wait_idle();
    exp_regs[23:16] = 8'h11;
    check("wr_rd_regs", reg_out, exp_regs);

    // Second command held while the first response is still transmitting
    send_cmd(16'hC155, 1'b1, 16'hC155);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin
      @(negedge clk_50m);
      n++;
    end
    if (n >= 50) fail_now("tx_busy_rise");
    d0 = tx_done_cnt;
    send_cmd(16'h8300, 1'b1, 16'h83A5);
    check("held_cmd_after_done", 128'(done_at_clr), 128'(d0 + 1));
    wait_idle();

    // Transmitter never goes busy: timeout error
    tx_dead = 1'b1;
    e0 = err_seen;
    send_cmd(16'hC0AA, 1'b1, 16'hC0AA);
    n = 0;
    while (err_seen == e0 && n < BUSY_TIMEOUT + 40) begin
      @(negedge clk_50m);
      n++;
    end
    if (n >= BUSY_TIMEOUT + 40) fail_now("timeout_err");
    check("timeout_cycles", 128'(err_cyc - tx_en_cyc), 128'(BUSY_TIMEOUT));
    check("timeout_idle", {127'h0, err_busy}, 128'h0);
    tx_dead = 1'b0;
    wait_idle();

    // Reset while waiting for the transmitter to finish
    send_cmd(16'hC033, 1'b1, 16'hC033);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin
      @(negedge clk_50m);
      n++;
    end
    if (n >= 50) fail_now("tx_busy_rise2");
    @(negedge clk_50m);
    chk_stable = 1'b0;
    @(posedge clk_50m);
    #1 rst_n = 1'b0;
    @(posedge clk_50m);
    #1;
    check("mid_rst_tx_en", {127'h0, tx_en}, 128'h0);
    check("mid_rst_tx_data", {112'h0, tx_data}, 128'h0);
    check("mid_rst_busy", {127'h0, busy}, 128'h0);
    check("mid_rst_err", {127'h0, err}, 128'h0);
    check("mid_rst_clr", {127'h0, rx_ready_clr}, 128'h0);
    check("mid_rst_regs", reg_out, 128'h0);
    rst_n = 1'b1;
    wait_idle();
    chk_stable = 1'b1;
    exp_regs = 128'h0;

    // Operational again after reset
    send_cmd(16'h4101, 1'b1, 16'h4101);
    wait_idle();
    exp_regs[15:8] = 8'h01;
    check("post_rst_regs", reg_out, exp_regs);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
